// File: rtl/dvp_frame_packer.sv
// dvp_frame_packer: whole-frame gated DVP pixel capture, packing WORD_BYTES pixels per write word
// with start-of-frame / end-of-line marks and per-frame line/frame geometry checking.
module dvp_frame_packer #(
  parameter int DATA_W     = 8,
  parameter int WORD_BYTES = 4,
  parameter int H_ACTIVE   = 1280,
  parameter int V_ACTIVE   = 800,
  parameter bit VSYNC_POL  = 1'b1,
  parameter int CNT_W      = 25
) (
  input  logic                         camera_pclk,
  input  logic                         rst_n,
  input  logic                         init_done,
  input  logic                         capture_en,
  input  logic                         camera_vsync,
  input  logic                         camera_href,
  input  logic [DATA_W-1:0]            camera_data,
  output logic                         wr_req,
  output logic [DATA_W*WORD_BYTES-1:0] wr_data,
  output logic                         wr_sof,
  output logic                         wr_eol,
  output logic                         frame_done,
  output logic                         frame_err,
  output logic [CNT_W-1:0]             word_cnt
);
  localparam int WW   = DATA_W * WORD_BYTES;
  localparam int PX_W = $clog2(H_ACTIVE + 1);
  localparam int LN_W = $clog2(V_ACTIVE + 2);
  localparam int BC_W = $clog2(WORD_BYTES + 1);
  localparam logic [1:0] IDLE = 2'd0, ARM = 2'd1, SYNC = 2'd2, ACTIVE = 2'd3;
  localparam logic [PX_W-1:0] PX_END  = PX_W'(H_ACTIVE);
  localparam logic [PX_W-1:0] PX_LAST = PX_W'(H_ACTIVE - 1);
  localparam logic [LN_W-1:0] LN_END  = LN_W'(V_ACTIVE);
  localparam logic [LN_W-1:0] LN_SAT  = LN_W'(V_ACTIVE + 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(WORD_BYTES - 1);

  logic [1:0]       state_q, state_d;
  logic             href_q, sof_pend_q, sof_pend_d, err_q, err_d;
  logic [PX_W-1:0]  px_q, px_d;
  logic [LN_W-1:0]  ln_q, ln_d;
  logic [BC_W-1:0]  bc_q, bc_d;
  logic [WW-1:0]    pack_q, pack_d, pack_new, wr_data_q, wr_data_d;
  logic             wr_req_q, wr_req_d, wr_sof_q, wr_sof_d, wr_eol_q, wr_eol_d;
  logic             done_q, done_d, ferr_q, ferr_d, bad;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic             vs_act, act, pv, keep, full, line_end, close;

  always_comb begin
    vs_act   = camera_vsync == VSYNC_POL;
    act      = state_q == ACTIVE;
    pv       = act & camera_href & !vs_act;
    keep     = pv & (px_q < PX_END) & (ln_q < LN_END);
    full     = keep & (bc_q == BC_LAST);
    line_end = act & !vs_act & href_q & !camera_href;
    close    = act & vs_act;
    bad      = err_q | camera_href | (ln_q != LN_END);
    state_d  = (state_q == IDLE && init_done && capture_en) ? ARM :
               (state_q == ARM && vs_act)                   ? SYNC :
               (state_q == SYNC && !vs_act)                 ? ACTIVE :
               close ? (capture_en ? SYNC : IDLE) : state_q;
    pack_new = pack_q;
    for (int i = 0; i < WORD_BYTES; i++)
      if (bc_q == BC_W'(i)) pack_new[i*DATA_W +: DATA_W] = camera_data;
    sof_pend_d = sof_pend_q | (state_q == SYNC && !vs_act);
    err_d      = err_q | (pv & !keep);
    px_d       = px_q;
    ln_d       = ln_q;
    bc_d       = bc_q;
    pack_d     = pack_q;
    wr_data_d  = wr_data_q;
    wr_req_d   = 1'b0;
    wr_eol_d   = 1'b0;
    done_d     = 1'b0;
    ferr_d     = 1'b0;
    if (keep) begin
      px_d   = px_q + 1'b1;
      pack_d = full ? '0 : pack_new;
      bc_d   = full ? '0 : bc_q + 1'b1;
      if (full) begin
        wr_req_d  = 1'b1;
        wr_data_d = pack_new;
        wr_eol_d  = px_q == PX_LAST;
      end
    end
    // Partial word left at line end goes out zero-padded and closes the line.
    if (line_end) begin
      if (bc_q != '0) begin
        wr_req_d  = 1'b1;
        wr_data_d = pack_q;
        wr_eol_d  = 1'b1;
        pack_d    = '0;
        bc_d      = '0;
      end
      err_d = err_d | (px_q != PX_END);
      px_d  = '0;
      ln_d  = (ln_q == LN_SAT) ? ln_q : ln_q + 1'b1;
    end
    if (close) begin
      done_d = !bad;
      ferr_d = bad;
      err_d  = 1'b0;
      px_d   = '0;
      ln_d   = '0;
      bc_d   = '0;
      pack_d = '0;
    end
    wr_sof_d   = wr_req_d & sof_pend_q;
    sof_pend_d = sof_pend_d & !wr_req_d;
    word_cnt_d = !wr_req_d ? word_cnt_q : sof_pend_q ? CNT_W'(1) :
                 (&word_cnt_q) ? word_cnt_q : word_cnt_q + 1'b1;
  end

  always_ff @(posedge camera_pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      href_q     <= 1'b0;
      sof_pend_q <= 1'b0;
      err_q      <= 1'b0;
      px_q       <= '0;
      ln_q       <= '0;
      bc_q       <= '0;
      pack_q     <= '0;
      wr_req_q   <= 1'b0;
      wr_data_q  <= '0;
      wr_sof_q   <= 1'b0;
      wr_eol_q   <= 1'b0;
      done_q     <= 1'b0;
      ferr_q     <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      href_q     <= camera_href;
      sof_pend_q <= sof_pend_d;
      err_q      <= err_d;
      px_q       <= px_d;
      ln_q       <= ln_d;
      bc_q       <= bc_d;
      pack_q     <= pack_d;
      wr_req_q   <= wr_req_d;
      wr_data_q  <= wr_data_d;
      wr_sof_q   <= wr_sof_d;
      wr_eol_q   <= wr_eol_d;
      done_q     <= done_d;
      ferr_q     <= ferr_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign wr_req     = wr_req_q;
  assign wr_data    = wr_data_q;
  assign wr_sof     = wr_sof_q;
  assign wr_eol     = wr_eol_q;
  assign frame_done = done_q;
  assign frame_err  = ferr_q;
  assign word_cnt   = word_cnt_q;
endmodule

// File: tb/tb_dvp_frame_packer.sv
// tb_dvp_frame_packer: directed DVP frames into two packer instances (8x4 and 6x1 geometry);
// expected words and frame pulses are queued by the stimulus and popped by negedge monitors.
module tb_dvp_frame_packer;
  logic clk = 1'b0, rst_n = 1'b0, init_done = 1'b0, capture_en = 1'b0;
  logic vs = 1'b0, hr = 1'b0, vs6 = 1'b0, hr6 = 1'b0;
  logic [7:0] d = '0, d6 = '0;
  logic wr_req8, wr_sof8, wr_eol8, fd8, fe8, wr_req6, wr_sof6, wr_eol6, fd6, fe6;
  logic [31:0] wr_data8, wr_data6;
  logic [24:0] wc8, wc6;
  typedef struct packed {logic [31:0] data; logic sof; logic eol;} exp_t;
  exp_t q8[$], q6[$];
  logic [1:0] fq8[$], fq6[$];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  dvp_frame_packer #(.H_ACTIVE(8), .V_ACTIVE(4)) u8 (
    .camera_pclk(clk), .rst_n(rst_n), .init_done(init_done), .capture_en(capture_en),
    .camera_vsync(vs), .camera_href(hr), .camera_data(d), .wr_req(wr_req8), .wr_data(wr_data8),
    .wr_sof(wr_sof8), .wr_eol(wr_eol8), .frame_done(fd8), .frame_err(fe8), .word_cnt(wc8));

  dvp_frame_packer #(.H_ACTIVE(6), .V_ACTIVE(1)) u6 (
    .camera_pclk(clk), .rst_n(rst_n), .init_done(init_done), .capture_en(capture_en),
    .camera_vsync(vs6), .camera_href(hr6), .camera_data(d6), .wr_req(wr_req6), .wr_data(wr_data6),
    .wr_sof(wr_sof6), .wr_eol(wr_eol6), .frame_done(fd6), .frame_err(fe6), .word_cnt(wc6));

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic unexpected(input string n, input logic [31:0] a);
    checks++;
    errors++;
    $display("FAIL %s: got unexpected output %0h, expected none", n, a);
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic [1:0] f;
    if (wr_req8) begin
      if (q8.size() == 0) unexpected("u8 wr_req", wr_data8);
      else begin
        e = q8.pop_front();
        chk("u8 wr_data", wr_data8, e.data);
        chk("u8 wr_sof", 32'(wr_sof8), 32'(e.sof));
        chk("u8 wr_eol", 32'(wr_eol8), 32'(e.eol));
      end
    end
    if (fd8 | fe8) begin
      if (fq8.size() == 0) unexpected("u8 frame pulse", {fd8, fe8});
      else begin
        f = fq8.pop_front();
        chk("u8 frame done/err", 32'({fd8, fe8}), 32'(f));
      end
    end
    if (wr_req6) begin
      if (q6.size() == 0) unexpected("u6 wr_req", wr_data6);
      else begin
        e = q6.pop_front();
        chk("u6 wr_data", wr_data6, e.data);
        chk("u6 wr_sof", 32'(wr_sof6), 32'(e.sof));
        chk("u6 wr_eol", 32'(wr_eol6), 32'(e.eol));
      end
    end
    if (fd6 | fe6) begin
      if (fq6.size() == 0) unexpected("u6 frame pulse", {fd6, fe6});
      else begin
        f = fq6.pop_front();
        chk("u6 frame done/err", 32'({fd6, fe6}), 32'(f));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pk(input logic [7:0] b);
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  task automatic pixels(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      hr = 1'b1;
      d = base + 8'(i);
      tick;
    end
  endtask

  task automatic line8(input logic [7:0] base, input int n);
    pixels(base, n);
    hr = 1'b0;
    d = '0;
    repeat (3) tick;
  endtask

  task automatic vpulse;
    vs = 1'b1;
    repeat (3) tick;
    vs = 1'b0;
    repeat (2) tick;
  endtask

  task automatic exp_line(input logic [7:0] b, input bit sof);
    q8.push_back('{data: pk(b), sof: sof, eol: 1'b0});
    q8.push_back('{data: pk(b + 8'd4), sof: 1'b0, eol: 1'b1});
  endtask

  task automatic frame8(input logic [7:0] base, input bit expect_words);
    for (int l = 0; l < 4; l++) begin
      if (expect_words) exp_line(base + 8'(8 * l), l == 0);
      line8(base + 8'(8 * l), 8);
    end
  endtask

  initial begin
    repeat (2) tick;
    chk("reset wr_req", 32'(wr_req8), 0);
    chk("reset frame_done/err", 32'({fd8, fe8}), 0);
    chk("reset word_cnt", 32'(wc8), 0);
    chk("reset state", 32'(u8.state_q), 0);
    rst_n = 1'b1;
    init_done = 1'b1;
    capture_en = 1'b1;
    tick;
    frame8(8'h00, 1'b0);
    vpulse;
    frame8(8'h00, 1'b1);
    fq8.push_back(2'b10);
    vpulse;
    chk("word_cnt after good frame", 32'(wc8), 8);
    // 6-pixel line into a 4-pixel word: second word is padded and marks the line end
    vs6 = 1'b1;
    repeat (3) tick;
    vs6 = 1'b0;
    repeat (2) tick;
    q6.push_back('{data: 32'hA3A2A1A0, sof: 1'b1, eol: 1'b0});
    q6.push_back('{data: 32'h0000A5A4, sof: 1'b0, eol: 1'b1});
    for (int i = 0; i < 6; i++) begin
      hr6 = 1'b1;
      d6 = 8'hA0 + 8'(i);
      tick;
    end
    hr6 = 1'b0;
    repeat (3) tick;
    fq6.push_back(2'b10);
    vs6 = 1'b1;
    repeat (3) tick;
    vs6 = 1'b0;
    tick;
    chk("u6 word_cnt", 32'(wc6), 2);
    // long first line: pixels 8 and 9 are dropped, frame flagged at close
    exp_line(8'h40, 1'b1);
    line8(8'h40, 10);
    for (int l = 1; l < 4; l++) begin
      exp_line(8'h48 + 8'(8 * l), 1'b0);
      line8(8'h48 + 8'(8 * l), 8);
    end
    fq8.push_back(2'b01);
    vpulse;
    chk("word_cnt after long-line frame", 32'(wc8), 8);
    // vsync mid-line: one full word out, partial pixel discarded
    q8.push_back('{data: 32'h73727170, sof: 1'b1, eol: 1'b0});
    fq8.push_back(2'b01);
    pixels(8'h70, 5);
    vs = 1'b1;
    tick;
    chk("state after abort", 32'(u8.state_q), 2);
    hr = 1'b0;
    repeat (2) tick;
    vs = 1'b0;
    repeat (2) tick;
    chk("word_cnt after abort", 32'(wc8), 1);
    // capture disabled mid-frame: this frame completes, then nothing more
    exp_line(8'h80, 1'b1);
    line8(8'h80, 8);
    exp_line(8'h88, 1'b0);
    line8(8'h88, 8);
    capture_en = 1'b0;
    exp_line(8'h90, 1'b0);
    line8(8'h90, 8);
    exp_line(8'h98, 1'b0);
    line8(8'h98, 8);
    fq8.push_back(2'b10);
    vpulse;
    chk("state idle after capture_en low", 32'(u8.state_q), 0);
    frame8(8'h00, 1'b0);
    vpulse;
    chk("state still idle", 32'(u8.state_q), 0);
    chk("word_cnt held while idle", 32'(wc8), 8);
    // asynchronous reset while a word is on the bus
    capture_en = 1'b1;
    tick;
    vpulse;
    pixels(8'h90, 4);
    chk("wr_req before reset", 32'(wr_req8), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("wr_req async reset", 32'(wr_req8), 0);
    chk("word_cnt async reset", 32'(wc8), 0);
    chk("state async reset", 32'(u8.state_q), 0);
    tick;
    pixels(8'h94, 1);
    rst_n = 1'b1;
    pixels(8'h95, 3);
    hr = 1'b0;
    repeat (3) tick;
    frame8(8'h00, 1'b0);
    vpulse;
    frame8(8'hA0, 1'b1);
    fq8.push_back(2'b10);
    vpulse;
    chk("word_cnt after reset frame", 32'(wc8), 8);
    repeat (3) tick;
    chk("u8 words outstanding", 32'(q8.size()), 0);
    chk("u8 frame pulses outstanding", 32'(fq8.size()), 0);
    chk("u6 words outstanding", 32'(q6.size()), 0);
    chk("u6 frame pulses outstanding", 32'(fq6.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
